mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's load/store address, store data, operation code and register result.
- Runs a req/gnt/rvalid transaction on the data bus, with byte-lane steering and load sign/zero extension.
- Registers the write-back triple (we, rd, data) for the register file.
- Stalls upstream while a bus transaction is outstanding.

---
 rtl/mem_access.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives a req/gnt/rvalid data bus for loads and stores,
// steers byte lanes, extends load data and registers the write-back triple.
package mem_access_pkg;
    typedef enum logic [3:0] {
        EX_ALU, EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW
    } ExCode;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  ExCode       ex_code_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_we_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [31:0] mem_raddr_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        stall_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_wdata_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int CNT_W = $clog2(BUS_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_store;
    ExCode             r_ld_code;
    logic [1:0]        r_off;
    logic [4:0]        r_rd;
    logic              r_pend_vld;
    logic [4:0]        r_pend_rd;
    logic [31:0]       r_pend_data;

    logic        w_is_load;
    logic        w_is_store;
    logic [31:0] w_addr;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_ld_data;
    logic        w_accept;
    logic        w_load_done;

    always_comb begin
        w_is_load  = ex_code_i inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
        w_is_store = ex_code_i inside {EX_SB, EX_SH, EX_SW};
        w_addr     = w_is_store ? mem_waddr_i : mem_raddr_i;
        w_misalign = ((ex_code_i inside {EX_LH, EX_LHU, EX_SH}) && w_addr[0]) ||
                     ((ex_code_i inside {EX_LW, EX_SW}) && (w_addr[1:0] != 2'b00));
        w_be    = 4'hF;
        w_wdata = mem_wdata_i;
        case (ex_code_i)
            EX_SB: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wdata = {4{mem_wdata_i[7:0]}};
            end
            EX_SH: begin
                w_be    = 4'b0011 << {w_addr[1], 1'b0};
                w_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Halfword loads are aligned, so the byte shifter also serves them.
    always_comb begin
        w_shifted = data_rdata_i >> {r_off, 3'b000};
        case (r_ld_code)
            EX_LB:   w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            EX_LBU:  w_ld_data = {24'h0, w_shifted[7:0]};
            EX_LH:   w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            EX_LHU:  w_ld_data = {16'h0, w_shifted[15:0]};
            default: w_ld_data = data_rdata_i;
        endcase
    end

    always_comb begin
        case (r_state)
            S_REQ:   stall_o = !(data_gnt_i && r_is_store);
            S_WAIT:  stall_o = !data_rvalid_i;
            default: stall_o = 1'b0;
        endcase
    end

    assign w_accept    = valid_i && !stall_o;
    assign w_load_done = (r_state == S_WAIT) && data_rvalid_i;

    // A non-memory op accepted while a load retires (or behind such an op) is
    // parked one cycle in r_pend_* so write-backs stay in program order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_is_store   <= 1'b0;
            r_ld_code    <= EX_ALU;
            r_off        <= 2'b00;
            r_rd         <= 5'd0;
            r_pend_vld   <= 1'b0;
            r_pend_rd    <= 5'd0;
            r_pend_data  <= 32'h0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_addr_o  <= 32'h0;
            data_be_o    <= 4'h0;
            data_wdata_o <= 32'h0;
            wb_we_o      <= 1'b0;
            wb_rd_o      <= 5'd0;
            wb_wdata_o   <= 32'h0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;

            case (r_state)
                S_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= r_is_store ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_rvalid_i) begin
                        r_state    <= S_IDLE;
                        wb_we_o    <= (r_rd != 5'd0);
                        wb_rd_o    <= r_rd;
                        wb_wdata_o <= w_ld_data;
                    end else if (r_cnt == CNT_LAST) begin
                        bus_err_o <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (!w_load_done && r_pend_vld) begin
                wb_we_o    <= 1'b1;
                wb_rd_o    <= r_pend_rd;
                wb_wdata_o <= r_pend_data;
                r_pend_vld <= 1'b0;
            end

            if (w_accept) begin
                if (!w_is_load && !w_is_store) begin
                    if (w_load_done || r_pend_vld) begin
                        r_pend_vld  <= reg_we_i;
                        r_pend_rd   <= rd_addr_i;
                        r_pend_data <= reg_wdata_i;
                    end else begin
                        wb_we_o    <= reg_we_i;
                        wb_rd_o    <= rd_addr_i;
                        wb_wdata_o <= reg_wdata_i;
                    end
                end else if (w_misalign) begin
                    misalign_o <= 1'b1;
                end else begin
                    r_state      <= S_REQ;
                    data_req_o   <= 1'b1;
                    data_we_o    <= w_is_store;
                    data_addr_o  <= {w_addr[31:2], 2'b00};
                    data_be_o    <= w_be;
                    data_wdata_o <= w_wdata;
                    r_is_store   <= w_is_store;
                    r_ld_code    <= ex_code_i;
                    r_off        <= w_addr[1:0];
                    r_rd         <= rd_addr_i;
                end
            end
        end
    end

    // The bus must not return load data in the same cycle it grants the request.
    assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == S_REQ) && !r_is_store && data_gnt_i && data_rvalid_i));

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios followed by randomized traffic, checked
// against a transaction-level model of the bus and an in-order write-back queue.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int BUS_TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    ExCode       ex_code_i;
    logic [4:0]  rd_addr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] mem_raddr_i;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        stall_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_wdata_o;
    logic        misalign_o;
    logic        bus_err_o;

    mem_access #(.BUS_TIMEOUT(BUS_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ex_code_i(ex_code_i),
        .rd_addr_i(rd_addr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .mem_raddr_i(mem_raddr_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .stall_o(stall_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_addr_o(data_addr_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_wdata_o(wb_wdata_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t wbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_stall = 0;

    // instruction currently offered to the DUT
    bit          cur_valid;
    ExCode       cur_op;
    logic [4:0]  cur_rd;
    bit          cur_we;
    logic [31:0] cur_res, cur_addr, cur_sdata, cur_rdata;
    int          cur_gdly, cur_rdly;

    // outstanding bus transaction as seen from the bus side
    bit          m_req, m_wait, m_store, exp_mis, exp_err;
    int          m_gcnt, m_rcnt, m_wait_n, m_off;
    ExCode       m_code;
    logic [4:0]  m_rd;
    logic [31:0] m_rdata, m_addr, m_wd;
    logic [3:0]  m_be;

    bit          wb_seen;
    logic [4:0]  last_wb_rd;
    logic [31:0] last_wb_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_load(input ExCode c);
        return c inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
    endfunction

    function automatic bit is_store(input ExCode c);
        return c inside {EX_SB, EX_SH, EX_SW};
    endfunction

    function automatic bit misaligned(input ExCode c, input logic [31:0] a);
        int sz;
        sz = (c inside {EX_LH, EX_LHU, EX_SH}) ? 2 : (c inside {EX_LW, EX_SW}) ? 4 : 1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] ld_expect(input ExCode c, input int off, input logic [31:0] w);
        logic [31:0] s, b, h;
        s = w >> (8 * off);
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (c)
            EX_LB:   return b[7]  ? b - 32'd256     : b;
            EX_LBU:  return b;
            EX_LH:   return h[15] ? h - 32'h10000   : h;
            EX_LHU:  return h;
            default: return w;
        endcase
    endfunction

    task automatic issue(input ExCode op, input int rd, input int we, input logic [31:0] res,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input int gdly, input int rdly, input logic [31:0] rdata);
        cur_valid = 1'b1;
        cur_op    = op;
        cur_rd    = 5'(rd);
        cur_we    = (we != 0);
        cur_res   = res;
        cur_addr  = addr;
        cur_sdata = sdata;
        cur_gdly  = gdly;
        cur_rdly  = rdly;
        cur_rdata = rdata;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic cycle();
        bit g, r, st, acc;
        wb_t e;
        if (wb_we_o === 1'b1) begin
            wb_seen      = 1'b1;
            last_wb_rd   = wb_rd_o;
            last_wb_data = wb_wdata_o;
            if (wbq.size() == 0) begin
                check("wb_spurious", 32'(wb_we_o), 32'h0);
            end else begin
                e = wbq.pop_front();
                check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                check("wb_data", wb_wdata_o, e.data);
            end
        end
        check("misalign", 32'(misalign_o), 32'(exp_mis));
        check("bus_err", 32'(bus_err_o), 32'(exp_err));
        check("req", 32'(data_req_o), 32'(m_req));
        if (m_req) begin
            check("req_addr", data_addr_o, m_addr);
            check("req_be", 32'(data_be_o), 32'(m_be));
            check("req_we", 32'(data_we_o), 32'(m_store));
            if (m_store) check("req_wdata", data_wdata_o, m_wd);
        end
        exp_mis = 1'b0;
        exp_err = 1'b0;

        g = m_req && (m_gcnt == 0);
        r = m_wait && (m_rcnt == 0);
        data_gnt_i    = g;
        data_rvalid_i = r;
        data_rdata_i  = r ? m_rdata : $urandom();
        st = (m_req && !(g && m_store)) || (m_wait && !r);

        valid_i     = cur_valid;
        ex_code_i   = cur_op;
        rd_addr_i   = cur_rd;
        reg_we_i    = cur_we;
        reg_wdata_i = cur_res;
        mem_raddr_i = is_load(cur_op)  ? cur_addr : 32'h0;
        mem_waddr_i = is_store(cur_op) ? cur_addr : 32'h0;
        mem_wdata_i = cur_sdata;
        #1;
        check("stall", 32'(stall_o), 32'(st));
        if (st) n_stall++;
        acc = cur_valid && !st;

        if (m_req) begin
            if (g) begin
                m_req = 1'b0;
                if (!m_store) begin
                    m_wait   = 1'b1;
                    m_wait_n = 0;
                end
            end else begin
                m_gcnt--;
            end
        end else if (m_wait) begin
            if (r) begin
                m_wait = 1'b0;
                if (m_rd != 5'd0) wbq.push_back('{rd: m_rd, data: ld_expect(m_code, m_off, m_rdata)});
            end else begin
                m_wait_n++;
                if (m_rcnt > 0) m_rcnt--;
                if (m_wait_n == BUS_TIMEOUT) begin
                    m_wait  = 1'b0;
                    exp_err = 1'b1;
                end
            end
        end

        if (acc) begin
            cur_valid = 1'b0;
            $display("[TB] accept op=%0d rd=%0d addr=%h sdata=%h res=%h", cur_op, cur_rd, cur_addr, cur_sdata, cur_res);
            if (!is_load(cur_op) && !is_store(cur_op)) begin
                if (cur_we) wbq.push_back('{rd: cur_rd, data: cur_res});
            end else if (misaligned(cur_op, cur_addr)) begin
                exp_mis = 1'b1;
            end else begin
                m_req   = 1'b1;
                m_store = is_store(cur_op);
                m_gcnt  = cur_gdly;
                m_rcnt  = cur_rdly;
                m_rdata = cur_rdata;
                m_code  = cur_op;
                m_off   = int'(cur_addr % 4);
                m_rd    = cur_rd;
                m_addr  = cur_addr & 32'hFFFF_FFFC;
                m_be    = (cur_op == EX_SB) ? 4'(1 << m_off) : (cur_op == EX_SH) ? 4'(3 << m_off) : 4'hF;
                m_wd    = (cur_op == EX_SB) ? (cur_sdata & 32'hFF) * 32'h0101_0101 :
                          (cur_op == EX_SH) ? (cur_sdata & 32'hFFFF) * 32'h0001_0001 : cur_sdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, k;
        ExCode op;
        logic [31:0] a;

        rst_n = 1'b0;
        valid_i = 1'b0; ex_code_i = EX_ALU; rd_addr_i = 5'd0; reg_we_i = 1'b0;
        reg_wdata_i = 32'h0; mem_raddr_i = 32'h0; mem_waddr_i = 32'h0; mem_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        cur_valid = 1'b0; cur_op = EX_ALU; cur_rd = 5'd0; cur_we = 1'b0;
        cur_res = 32'h0; cur_addr = 32'h0; cur_sdata = 32'h0; cur_rdata = 32'h0;
        cur_gdly = 0; cur_rdly = 0;
        m_req = 1'b0; m_wait = 1'b0; m_store = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
        m_gcnt = 0; m_rcnt = 0; m_wait_n = 0; m_off = 0; m_code = EX_ALU; m_rd = 5'd0;
        m_rdata = 32'h0; m_addr = 32'h0; m_wd = 32'h0; m_be = 4'h0;
        wb_seen = 1'b0; last_wb_rd = 5'd0; last_wb_data = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_req", 32'(data_req_o), 32'h0);
        check("rst_we", 32'(data_we_o), 32'h0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_be", 32'(data_be_o), 32'h0);
        check("rst_wdata", data_wdata_o, 32'h0);
        check("rst_wb_we", 32'(wb_we_o), 32'h0);
        check("rst_wb_rd", 32'(wb_rd_o), 32'h0);
        check("rst_wb_data", wb_wdata_o, 32'h0);
        check("rst_misalign", 32'(misalign_o), 32'h0);
        check("rst_bus_err", 32'(bus_err_o), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI: one-cycle write-back, no stall
        s0 = n_stall;
        issue(EX_ALU, 5, 1, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 32'h0);
        cycle();
        check("addi_wb_we", 32'(wb_we_o), 32'h1);
        check("addi_wb_rd", 32'(wb_rd_o), 32'd5);
        check("addi_wb_data", wb_wdata_o, 32'h1234_5678);
        cycle();
        check("addi_stall_cycles", n_stall - s0, 32'd0);

        // SB with a three-cycle grant delay
        s0 = n_stall;
        issue(EX_SB, 1, 0, 32'h0, 32'h0000_1003, 32'h0000_00AB, 3, 0, 32'h0);
        cycle();
        check("sb_addr", data_addr_o, 32'h0000_1000);
        check("sb_be", 32'(data_be_o), 32'h8);
        check("sb_wdata", data_wdata_o, 32'hABAB_ABAB);
        repeat (4) cycle();
        check("sb_stall_cycles", n_stall - s0, 32'd3);
        check("sb_req_dropped", 32'(data_req_o), 32'h0);

        // LH / LHU on the upper halfword
        wb_seen = 1'b0;
        issue(EX_LH, 7, 1, 32'h0, 32'h0000_2002, 32'h0, 2, 1, 32'h8001_0000);
        for (int i = 0; i < 20 && !wb_seen; i++) cycle();
        check("lh_done", 32'(wb_seen), 32'h1);
        check("lh_rd", 32'(last_wb_rd), 32'd7);
        check("lh_data", last_wb_data, 32'hFFFF_8001);
        wb_seen = 1'b0;
        issue(EX_LHU, 8, 1, 32'h0, 32'h0000_2002, 32'h0, 2, 1, 32'h8001_0000);
        for (int i = 0; i < 20 && !wb_seen; i++) cycle();
        check("lhu_done", 32'(wb_seen), 32'h1);
        check("lhu_data", last_wb_data, 32'h0000_8001);

        // misaligned LW
        s0 = n_stall;
        issue(EX_LW, 9, 1, 32'h0, 32'h0000_3001, 32'h0, 0, 0, 32'h0);
        cycle();
        check("lw_mis_pulse", 32'(misalign_o), 32'h1);
        check("lw_mis_noreq", 32'(data_req_o), 32'h0);
        check("lw_mis_wb", 32'(wb_we_o), 32'h0);
        cycle();
        check("lw_mis_stall", n_stall - s0, 32'd0);

        // LW granted, rvalid never arrives
        s0 = n_stall;
        issue(EX_LW, 10, 1, 32'h0, 32'h0000_4000, 32'h0, 0, -1, 32'h0);
        cycle();
        k = 1;
        while (k <= 40) begin
            cycle();
            if (bus_err_o === 1'b1) break;
            k++;
        end
        check("tmo_cycles", k, 32'd17);
        check("tmo_stall_cycles", n_stall - s0, 32'd17);
        check("tmo_stall_released", 32'(stall_o), 32'h0);
        check("tmo_wb", 32'(wb_we_o), 32'h0);
        cycle();

        // reset asserted while a store waits for grant
        issue(EX_SW, 3, 0, 32'h0, 32'h0000_5004, 32'hCAFE_F00D, 10, 0, 32'h0);
        cycle();
        cycle();
        check("pre_rst_req", 32'(data_req_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(data_req_o), 32'h0);
        check("mid_rst_stall", 32'(stall_o), 32'h0);
        m_req = 1'b0; m_wait = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(EX_SW, 4, 0, 32'h0, 32'h0000_6008, 32'hDEAD_BEEF, 1, 0, 32'h0);
        cycle();
        check("sw_addr", data_addr_o, 32'h0000_6008);
        check("sw_be", 32'(data_be_o), 32'hF);
        check("sw_wdata", data_wdata_o, 32'hDEAD_BEEF);
        check("sw_we", 32'(data_we_o), 32'h1);
        repeat (3) cycle();
        check("sw_req_dropped", 32'(data_req_o), 32'h0);

        // randomized back-to-back traffic
        for (int it = 0; it < 400; it++) begin
            if (!cur_valid && ($urandom_range(0, 3) != 0)) begin
                op = ExCode'($urandom_range(0, 8));
                a  = $urandom();
                if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
                issue(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 1)), $urandom(), a,
                      $urandom(), int'($urandom_range(0, 2)),
                      ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)), $urandom());
            end
            cycle();
        end
        cur_valid = 1'b0;
        repeat (40) cycle();
        check("wbq_drained", wbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
